baud_tick_gen: RTL
==================

Name: baud_tick_gen

Overview:
Parametrised baud/oversample tick generator for the UART and serial paths. It replaces fixed-divisor tick generation with a runtime-programmable integer+fractional divisor. It produces an oversample tick, a mid-bit sample tick and a bit tick. Divisor updates are shadowed and applied glitch-free at period boundaries.

Parameters:
CNT_W, 16, width of the integer divisor and the period counter
FRAC_W, 4, width of the fractional divisor and the accumulator (fraction = div_frac / 2^FRAC_W)
OSR, 16, oversample ratio, i.e. os_ticks per bit; legal range 2..256, even
DEF_DIV, 651, integer divisor active after reset
DEF_FRAC, 0, fractional divisor active after reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; when low, counters hold and all ticks stay 0
sync_clr  in  1  synchronous restart of count, phase and accumulator
div_int  in  CNT_W  requested integer divisor
div_frac  in  FRAC_W  requested fractional divisor
div_load  in  1  one-cycle strobe; captures div_int/div_frac into the pending register
div_ack  out  1  one-cycle pulse when the pending divisor becomes active
os_tick  out  1  oversample tick, one cycle wide
mid_tick  out  1  tick at bit centre, one cycle wide
bit_tick  out  1  tick at bit end, one cycle wide

Behaviour:
- Reset (async, active-high):
  - count=0, phase=0, acc=0, carry=0.
  - Active divisor = DEF_DIV/DEF_FRAC; pending flag=0.
  - All outputs 0.
- Period counter:
  - limit = max(div_act,1) + carry. A divisor of 0 is treated as 1, so the minimum period is 2 cycles.
  - With en=1: if count < limit, count++. If count == limit, count←0 ("wrap") and os_tick=1 in the next cycle.
  - Period = limit+1 clocks. With DEF_DIV=651 and frac=0, os_tick fires every 652 clocks.
- Fractional accumulator:
  - On each wrap, {carry, acc} ← acc + frac_act (FRAC_W+1-bit sum).
  - The resulting carry lengthens the following period by 1 clock.
  - Average period = div_int + 1 + div_frac/2^FRAC_W.
- Phase counter:
  - Counts 0..OSR-1 and advances on each wrap.
  - mid_tick = os_tick qualified with the wrap that moves phase from OSR/2-1 to OSR/2.
  - bit_tick = os_tick qualified with the wrap that moves phase from OSR-1 to 0.
  - Both are registered alongside os_tick, so they are coincident with it.
- Divisor update:
  - div_load latches div_int/div_frac into the pending register and sets the pending flag.
  - A second div_load before application overwrites the pending value; only one div_ack results.
  - The pending value is applied (active ← pending, flag cleared, div_ack=1 the next cycle) on the first of these events:
    - a wrap;
    - any cycle with en=0;
    - sync_clr.
  - div_load in the same cycle as a wrap: the new value is captured but not applied at that wrap. It applies at the next qualifying event. The period in progress is never altered mid-count.
- en=0: count, phase and acc hold; os_tick, mid_tick and bit_tick are 0; a pending divisor is still applied as above.
- sync_clr: count, phase, acc and carry ← 0, and all ticks are 0 the next cycle. It has priority over en and wrap. The period restarts from count=0 on the following cycle.
- Outputs are registered with no combinational path from inputs. Tick latency from wrap is exactly 1 clock.
- Reset mid-period: immediate async return to reset values; the next period starts with DEF_DIV.

Test Plan:
- Reset release, en=1, defaults: first os_tick 652 clocks after the first counting edge, then every 652; bit_tick every 10432 clocks; mid_tick at 8th os_tick of each bit.
- div_int=3, div_frac=8 loaded with en=0, then en=1: os_tick periods 4,4,5,4,5,… (mean 4.5); div_ack one pulse after load.
- While running at div=9, pulse div_load with div_int=4 in the same cycle count==limit: the following period is still 10 clocks, then 5; div_ack coincides with the second wrap's tick cycle.
- en low for 50 clocks mid-period at count=5: no ticks during the low time; on re-enable, counting resumes from 5 and phase is unchanged.
- sync_clr asserted at phase=7, count=300: all ticks 0; count=0, phase=0; next os_tick 652 clocks later; bit_tick only after 16 further os_ticks.
- div_int=0: os_tick every 2 clocks; async reset asserted mid-period: outputs 0 immediately and the default divisor is restored.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Baud/oversample tick generator with integer+fractional runtime divisor.
// Divisor changes are shadowed and applied only at period boundaries or while idle.
module baud_tick_gen #(
   parameter int CNT_W    = 16,
   parameter int FRAC_W   = 4,
   parameter int OSR      = 16,
   parameter int DEF_DIV  = 651,
   parameter int DEF_FRAC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sync_clr,
   input  logic [CNT_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   output logic              div_ack,
   output logic              os_tick,
   output logic              mid_tick,
   output logic              bit_tick
);

   localparam int PH_W = (OSR > 2) ? $clog2(OSR) : 1;

   localparam logic [PH_W-1:0]   PH_MID   = PH_W'(OSR / 2 - 1);
   localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OSR - 1);
   localparam logic [CNT_W-1:0]  DIV_RST  = CNT_W'(DEF_DIV);
   localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_W'(DEF_FRAC);

   // One extra bit so that a full-scale divisor plus carry cannot overflow.
   logic [CNT_W:0]      count_q, count_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [FRAC_W-1:0]   acc_q, acc_d;
   logic                carry_q, carry_d;

   logic [CNT_W-1:0]    div_act_q, div_act_d;
   logic [FRAC_W-1:0]   frac_act_q, frac_act_d;
   logic [CNT_W-1:0]    pend_int_q, pend_int_d;
   logic [FRAC_W-1:0]   pend_frac_q, pend_frac_d;
   logic                pend_q, pend_d;

   logic                os_q, os_d;
   logic                mid_q, mid_d;
   logic                bit_q, bit_d;
   logic                ack_q, ack_d;

   logic [CNT_W-1:0]    div_eff;
   logic [CNT_W:0]      limit;
   logic [FRAC_W:0]     acc_sum;
   logic                wrap;
   logic                apply;

   always_comb begin
      div_eff = (div_act_q == '0) ? CNT_W'(1) : div_act_q;
      limit   = {1'b0, div_eff} + (CNT_W + 1)'(carry_q);
      acc_sum = {1'b0, acc_q} + {1'b0, frac_act_q};
      // A divisor applied while idle may leave count above the new limit.
      wrap    = en && !sync_clr && (count_q >= limit);
      // A load coinciding with an event is deferred to the next event.
      apply   = pend_q && !div_load && (wrap || !en || sync_clr);
   end

   always_comb begin
      count_d     = count_q;
      phase_d     = phase_q;
      acc_d       = acc_q;
      carry_d     = carry_q;
      div_act_d   = div_act_q;
      frac_act_d  = frac_act_q;
      pend_int_d  = pend_int_q;
      pend_frac_d = pend_frac_q;
      pend_d      = pend_q;

      if (sync_clr) begin
         count_d = '0;
         phase_d = '0;
         acc_d   = '0;
         carry_d = 1'b0;
      end else if (en) begin
         if (wrap) begin
            count_d = '0;
            acc_d   = acc_sum[FRAC_W-1:0];
            carry_d = acc_sum[FRAC_W];
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
         end else begin
            count_d = count_q + (CNT_W + 1)'(1);
         end
      end

      if (div_load) begin
         pend_int_d  = div_int;
         pend_frac_d = div_frac;
         pend_d      = 1'b1;
      end else if (apply) begin
         pend_d = 1'b0;
      end

      if (apply) begin
         div_act_d  = pend_int_q;
         frac_act_d = pend_frac_q;
      end

      os_d  = wrap;
      mid_d = wrap && (phase_q == PH_MID);
      bit_d = wrap && (phase_q == PH_LAST);
      ack_d = apply;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q     <= '0;
         phase_q     <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         div_act_q   <= DIV_RST;
         frac_act_q  <= FRAC_RST;
         pend_int_q  <= '0;
         pend_frac_q <= '0;
         pend_q      <= 1'b0;
         os_q        <= 1'b0;
         mid_q       <= 1'b0;
         bit_q       <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         count_q     <= count_d;
         phase_q     <= phase_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         div_act_q   <= div_act_d;
         frac_act_q  <= frac_act_d;
         pend_int_q  <= pend_int_d;
         pend_frac_q <= pend_frac_d;
         pend_q      <= pend_d;
         os_q        <= os_d;
         mid_q       <= mid_d;
         bit_q       <= bit_d;
         ack_q       <= ack_d;
      end
   end

   assign os_tick  = os_q;
   assign mid_tick = mid_q;
   assign bit_tick = bit_q;
   assign div_ack  = ack_q;

endmodule
